// File: rtl/mem_pkg.sv
// Shared geometry, types and FSM encoding for the memory-side line responder.
// Line geometry is owned here; the responder's size parameters must agree with it.
package mem_pkg;

  localparam int MEM_ADDR_W = 32;
  localparam int MEM_WORDS  = 4;
  localparam int MEM_NLINES = 1024;

  localparam int LINE_W = 32 * MEM_WORDS;
  localparam int OFF_W  = $clog2(MEM_WORDS);
  localparam int IDX_W  = $clog2(MEM_NLINES);

  typedef logic [MEM_WORDS-1:0][31:0] line_t;

  typedef struct packed {
    logic                  we;
    logic [MEM_ADDR_W-1:0] addr;
    line_t                 wdata;
  } mem_req_t;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    BURST,
    ACK
  } mem_rsp_state_e;

endpackage

// File: rtl/mem_line_array.sv
// Single-port MEM_LINES x line_t storage: synchronous write, combinational read.
module mem_line_array
  import mem_pkg::*;
#(
  parameter int DEPTH = MEM_NLINES
) (
  input  logic             clk_i,
  input  logic             we_i,
  input  logic [IDX_W-1:0] addr_i,
  input  line_t            wdata_i,
  output line_t            rdata_o
);

  // NOTE: the array has no reset; clearing it would turn the RAM into flops,
  // and its contents are expected to survive a controller reset.
  line_t r_mem [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) r_mem[addr_i] <= wdata_i;
  end

  assign rdata_o = r_mem[addr_i];

endmodule

// File: rtl/mem_line_responder.sv
// Line read/write responder with fixed access latency and a 32-bit beat burst.
// Define MEM_CWF_EN for critical-word-first beat order; otherwise beats run 0..N-1.
module mem_line_responder
  import mem_pkg::*;
#(
  parameter int ADDR_W         = MEM_ADDR_W,
  parameter int WORDS_PER_LINE = MEM_WORDS,
  parameter int MEM_LINES      = MEM_NLINES,
  parameter int LATENCY        = 8
) (
  input  logic                              clk_i,
  input  logic                              rst_i,
  input  logic                              req_vld_i,
  output logic                              req_rdy_o,
  input  logic                              req_we_i,
  input  logic [ADDR_W-1:0]                 req_addr_i,
  input  logic [32*WORDS_PER_LINE-1:0]      req_wdata_i,
  output logic                              resp_vld_o,
  input  logic                              resp_rdy_i,
  output logic [31:0]                       resp_data_o,
  output logic [$clog2(WORDS_PER_LINE)-1:0] resp_beat_o,
  output logic                              resp_last_o,
  output logic                              wr_ack_o,
  output logic                              busy_o
);

`ifdef MEM_CWF_EN
  localparam bit CWF = 1'b1;
`else
  localparam bit CWF = 1'b0;
`endif

  localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  mem_rsp_state_e r_state, w_state_nxt;

  logic             r_we;
  logic [IDX_W-1:0] r_idx;
  logic [OFF_W-1:0] r_start;
  line_t            r_wdata;
  line_t            r_line;
  logic [CNT_W-1:0] r_cnt;
  logic [OFF_W-1:0] r_beat;

  logic             w_accept;
  logic             w_enter_burst;
  logic             w_is_last;
  logic [OFF_W-1:0] w_start;
  logic [OFF_W-1:0] w_last_beat;
  logic [IDX_W-1:0] w_mem_idx;
  logic             w_mem_we;
  line_t            w_rdata;
  logic             w_unused;

  // Byte-lane bits and everything above the index are don't-care, so addresses alias.
  assign w_unused = ^{req_addr_i[1:0], req_addr_i[ADDR_W-1:2+OFF_W+IDX_W]};

  assign w_accept      = req_vld_i && (r_state == IDLE);
  assign w_enter_burst = (w_state_nxt == BURST) && (r_state != BURST);
  assign w_start       = !CWF ? '0 :
                         (r_state == IDLE) ? req_addr_i[2 +: OFF_W] : r_start;
  assign w_last_beat   = CWF ? r_start - 1'b1 : '1;
  assign w_is_last     = (r_beat == w_last_beat);

  // The single port looks at the incoming index while idle so a LATENCY==1 read
  // can snapshot its line on the same edge that accepts it.
  assign w_mem_idx = (r_state == IDLE) ? req_addr_i[2+OFF_W +: IDX_W] : r_idx;
  assign w_mem_we  = (r_state == ACK) && !rst_i;

  mem_line_array #(
    .DEPTH (MEM_LINES)
  ) u_array (
    .clk_i   (clk_i),
    .we_i    (w_mem_we),
    .addr_i  (w_mem_idx),
    .wdata_i (r_wdata),
    .rdata_o (w_rdata)
  );

  // NOTE: every signal driven here gets a default first, so no path can infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    req_rdy_o   = 1'b0;
    resp_vld_o  = 1'b0;
    resp_data_o = '0;
    resp_beat_o = r_beat;
    resp_last_o = 1'b0;
    wr_ack_o    = 1'b0;
    busy_o      = (r_state != IDLE);
    case (r_state)
      IDLE: begin
        req_rdy_o = 1'b1;
        if (w_accept) begin
          if (LATENCY == 1) w_state_nxt = req_we_i ? ACK : BURST;
          else              w_state_nxt = WAIT;
        end
      end
      WAIT: begin
        if (r_cnt == CNT_W'(1)) w_state_nxt = r_we ? ACK : BURST;
      end
      BURST: begin
        resp_vld_o  = 1'b1;
        resp_data_o = r_line[r_beat];
        resp_last_o = w_is_last;
        if (resp_rdy_i && w_is_last) w_state_nxt = IDLE;
      end
      ACK: begin
        wr_ack_o    = 1'b1;
        w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_beat  <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == IDLE)      r_cnt <= CNT_W'(LATENCY - 1);
      else if (r_state == WAIT) r_cnt <= r_cnt - 1'b1;
      if (w_enter_burst)                         r_beat <= w_start;
      else if (r_state == BURST && resp_rdy_i)   r_beat <= r_beat + 1'b1;
    end
  end

  // NOTE: request and line registers carry no reset; they are only read in states
  // reachable after a fresh accept, so leaving them out keeps reset fan-out small.
  always_ff @(posedge clk_i) begin
    if (w_accept) begin
      r_we    <= req_we_i;
      r_idx   <= req_addr_i[2+OFF_W +: IDX_W];
      r_start <= req_addr_i[2 +: OFF_W];
      r_wdata <= req_wdata_i;
    end
    if (w_enter_burst) r_line <= w_rdata;
  end

endmodule
